// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic phase controller: FSM states and per-phase lamp codes.
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10,
        ST_FLASH  = 2'b11
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_GREEN  = 2'b01;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_DARK   = 2'b11;

endpackage

// File: rtl/traffic_phase_controller_switch_debouncer.sv
// Manual-advance switch conditioning: 2-flop synchroniser, stability counter, one-cycle rise pulse.
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_async,
    output logic rise
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    // Level flips on the DEBOUNCE_CYCLES-th consecutive differing sample; any agreeing sample restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sw_async;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/traffic_phase_controller.sv
// Multi-phase traffic sequencer: GREEN -> YELLOW -> ALL-RED per approach, with manual advance, hold and night flash.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int unsigned NUM_PHASES      = 4,
    parameter int unsigned CNT_W           = 32,
    parameter int unsigned GREEN_CYCLES    = 100,
    parameter int unsigned YELLOW_CYCLES   = 30,
    parameter int unsigned ALLRED_CYCLES   = 10,
    parameter int unsigned MIN_GREEN       = 20,
    parameter int unsigned FLASH_CYCLES    = 50,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          switch,
    input  logic                          hold,
    input  logic                          flash_mode,
    output logic [2*NUM_PHASES-1:0]       lights,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [1:0]                    state,
    output logic [CNT_W-1:0]              counter,
    output logic                          req_pending
);

    localparam int unsigned PH_W      = $clog2(NUM_PHASES);
    localparam int unsigned EARLY_MAX = (MIN_GREEN < GREEN_CYCLES) ? GREEN_CYCLES - 1 - MIN_GREEN : 0;

    localparam logic [CNT_W-1:0] CNT_GREEN  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_YELLOW = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ALLRED = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FLASH  = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_EARLY  = CNT_W'(EARLY_MAX);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(NUM_PHASES - 1);

    state_t                  state_q, state_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    dark_q, dark_d;
    logic                    req_q, req_d;
    logic [2*NUM_PHASES-1:0] lights_q, lights_d;
    logic                    cnt_zero;
    logic                    clr_req;
    logic                    sw_rise;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk     (clk),
        .rst_n   (reset),
        .sw_async(switch),
        .rise    (sw_rise)
    );

    assign cnt_zero = (cnt_q == '0);

    // Sequencing; hold freezes everything except the request path.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        dark_d  = dark_q;
        clr_req = 1'b0;
        if (!hold) begin
            case (state_q)
                ST_ALLRED: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (flash_mode) begin
                        state_d = ST_FLASH;
                        cnt_d   = CNT_FLASH;
                        dark_d  = 1'b0;
                    end else begin
                        state_d = ST_GREEN;
                        cnt_d   = CNT_GREEN;
                    end
                end
                ST_GREEN: begin
                    if (cnt_zero || (req_q && (cnt_q <= CNT_EARLY))) begin
                        state_d = ST_YELLOW;
                        cnt_d   = CNT_YELLOW;
                        clr_req = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_YELLOW: begin
                    if (cnt_zero) begin
                        state_d = ST_ALLRED;
                        cnt_d   = CNT_ALLRED;
                        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_FLASH: begin
                    if (!flash_mode) begin
                        state_d = ST_ALLRED;
                        cnt_d   = CNT_ALLRED;
                        phase_d = '0;
                        dark_d  = 1'b0;
                    end else if (cnt_zero) begin
                        cnt_d  = CNT_FLASH;
                        dark_d = ~dark_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_ALLRED;
                    cnt_d   = CNT_ALLRED;
                end
            endcase
        end

        // A fresh debounced edge beats a same-cycle clear, except in FLASH where requests are discarded.
        if (state_q == ST_FLASH) begin
            req_d = 1'b0;
        end else if (sw_rise) begin
            req_d = 1'b1;
        end else if (clr_req) begin
            req_d = 1'b0;
        end else begin
            req_d = req_q;
        end

        lights_d = '0;
        for (int p = 0; p < int'(NUM_PHASES); p++) begin
            if (state_d == ST_FLASH) begin
                lights_d[2*p +: 2] = dark_d ? LAMP_DARK : LAMP_YELLOW;
            end else if ((state_d == ST_GREEN) && (PH_W'(p) == phase_d)) begin
                lights_d[2*p +: 2] = LAMP_GREEN;
            end else if ((state_d == ST_YELLOW) && (PH_W'(p) == phase_d)) begin
                lights_d[2*p +: 2] = LAMP_YELLOW;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_ALLRED;
            phase_q  <= '0;
            cnt_q    <= CNT_ALLRED;
            dark_q   <= 1'b0;
            req_q    <= 1'b0;
            lights_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            dark_q   <= dark_d;
            req_q    <= req_d;
            lights_q <= lights_d;
        end
    end

    assign lights      = lights_q;
    assign phase       = phase_q;
    assign state       = state_q;
    assign counter     = cnt_q;
    assign req_pending = req_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: directed stimulus pushes hand-computed snapshots, a negedge monitor checks them.
module tb_traffic_phase_controller;

    localparam logic [1:0] S_AR = 2'b00;
    localparam logic [1:0] S_G  = 2'b01;
    localparam logic [1:0] S_Y  = 2'b10;
    localparam logic [1:0] S_F  = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       switch;
    logic       hold;
    logic       flash_mode;
    logic [5:0] lights_o;
    logic [1:0] phase_o;
    logic [1:0] state_o;
    logic [7:0] counter_o;
    logic       req_o;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic [1:0] ph;
        logic [7:0] cnt;
        logic [5:0] lt;
        logic       rq;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_n   = 0;

    traffic_phase_controller #(
        .NUM_PHASES     (3),
        .CNT_W          (8),
        .GREEN_CYCLES   (8),
        .YELLOW_CYCLES  (3),
        .ALLRED_CYCLES  (2),
        .MIN_GREEN      (4),
        .FLASH_CYCLES   (5),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .switch     (switch),
        .hold       (hold),
        .flash_mode (flash_mode),
        .lights     (lights_o),
        .phase      (phase_o),
        .state      (state_o),
        .counter    (counter_o),
        .req_pending(req_o)
    );

    always #5 clk = ~clk;

    // Monitor: compares every queued snapshot against the outputs held mid-cycle.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            n_checks++;
            if ({state_o, phase_o, counter_o, lights_o, req_o} !== {cur.st, cur.ph, cur.cnt, cur.lt, cur.rq}) begin
                n_fail++;
                $display("FAIL %s: got st=%0d ph=%0d cnt=%0d lights=%b req=%b, expected st=%0d ph=%0d cnt=%0d lights=%b req=%b",
                         cur.name, state_o, phase_o, counter_o, lights_o, req_o,
                         cur.st, cur.ph, cur.cnt, cur.lt, cur.rq);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic goto(input int e);
        while (edge_n < e) step();
    endtask

    task automatic chk(input string nm, input logic [1:0] st, input logic [1:0] ph,
                       input logic [7:0] cnt, input logic [5:0] lt, input logic rq);
        exp_t e;
        e.name = nm;
        e.st   = st;
        e.ph   = ph;
        e.cnt  = cnt;
        e.lt   = lt;
        e.rq   = rq;
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        reset      = 1'b0;
        switch     = 1'b0;
        hold       = 1'b0;
        flash_mode = 1'b0;
        step();
        step();
        chk("in_reset", S_AR, 2'd0, 8'd1, 6'b000000, 1'b0);
        step();
        reset  = 1'b1;
        edge_n = 0;
        chk("released", S_AR, 2'd0, 8'd1, 6'b000000, 1'b0);

        // Free-running cycle through all three approaches.
        goto(1);  chk("ar0_cnt0",   S_AR, 2'd0, 8'd0, 6'b000000, 1'b0);
        goto(2);  chk("g0_enter",   S_G,  2'd0, 8'd7, 6'b000001, 1'b0);
        goto(9);  chk("g0_cnt0",    S_G,  2'd0, 8'd0, 6'b000001, 1'b0);
        goto(10); chk("y0_enter",   S_Y,  2'd0, 8'd2, 6'b000010, 1'b0);
        goto(12); chk("y0_cnt0",    S_Y,  2'd0, 8'd0, 6'b000010, 1'b0);
        goto(13); chk("ar1_enter",  S_AR, 2'd1, 8'd1, 6'b000000, 1'b0);
        goto(15); chk("g1_enter",   S_G,  2'd1, 8'd7, 6'b000100, 1'b0);
        goto(28); chk("g2_enter",   S_G,  2'd2, 8'd7, 6'b010000, 1'b0);

        // Switch held 10 cycles from edge 39: request lands after edge 45, cuts green at counter 3.
        goto(38); switch = 1'b1;
        goto(41); chk("g0_wrap",    S_G,  2'd0, 8'd7, 6'b000001, 1'b0);
        goto(44); chk("req_early",  S_G,  2'd0, 8'd4, 6'b000001, 1'b0);
        goto(45); chk("req_set",    S_G,  2'd0, 8'd3, 6'b000001, 1'b1);
        goto(46); chk("early_y",    S_Y,  2'd0, 8'd2, 6'b000010, 1'b0);
        goto(48); switch = 1'b0;
        goto(51); chk("g1_full",    S_G,  2'd1, 8'd7, 6'b000100, 1'b0);
        goto(58); chk("one_req",    S_G,  2'd1, 8'd0, 6'b000100, 1'b0);
        goto(59); chk("y1_natural", S_Y,  2'd1, 8'd2, 6'b001000, 1'b0);

        // Three-cycle glitch must not register.
        goto(60); switch = 1'b1;
        goto(63); switch = 1'b0;
        goto(67); chk("glitch_g2",  S_G,  2'd2, 8'd4, 6'b010000, 1'b0);
        goto(71); chk("glitch_full",S_G,  2'd2, 8'd0, 6'b010000, 1'b0);
        goto(72); chk("y2_enter",   S_Y,  2'd2, 8'd2, 6'b100000, 1'b0);

        // Hold for five edges in YELLOW at counter 1.
        goto(73); hold = 1'b1;
        goto(74); chk("hold_first", S_Y,  2'd2, 8'd1, 6'b100000, 1'b0);
        goto(78); chk("hold_last",  S_Y,  2'd2, 8'd1, 6'b100000, 1'b0);
        hold = 1'b0;
        goto(79); chk("hold_resume",S_Y,  2'd2, 8'd0, 6'b100000, 1'b0);
        goto(80); chk("ph_wrap",    S_AR, 2'd0, 8'd1, 6'b000000, 1'b0);
        goto(82); chk("g0_again",   S_G,  2'd0, 8'd7, 6'b000001, 1'b0);

        // Flash requested mid-green: clearance completes before FLASH.
        goto(96);  flash_mode = 1'b1;
        goto(103); chk("fl_y1",     S_Y,  2'd1, 8'd2, 6'b001000, 1'b0);
        goto(106); chk("fl_ar2",    S_AR, 2'd2, 8'd1, 6'b000000, 1'b0);
        goto(108); chk("fl_enter",  S_F,  2'd2, 8'd4, 6'b101010, 1'b0);
        switch = 1'b1;
        goto(112); chk("fl_cnt0",   S_F,  2'd2, 8'd0, 6'b101010, 1'b0);
        switch = 1'b0;
        goto(113); chk("fl_dark",   S_F,  2'd2, 8'd4, 6'b111111, 1'b0);
        goto(116); chk("fl_noreq",  S_F,  2'd2, 8'd1, 6'b111111, 1'b0);
        goto(118); chk("fl_yel",    S_F,  2'd2, 8'd4, 6'b101010, 1'b0);
        goto(119); flash_mode = 1'b0;
        goto(120); chk("fl_exit",   S_AR, 2'd0, 8'd1, 6'b000000, 1'b0);
        goto(122); chk("fl_g0",     S_G,  2'd0, 8'd7, 6'b000001, 1'b0);

        // Pending request in YELLOW phase 2, then an async reset pulse between clock edges.
        goto(150); switch = 1'b1;
        goto(156); chk("y2_pre",    S_Y,  2'd2, 8'd2, 6'b100000, 1'b0);
        goto(157); chk("y2_req",    S_Y,  2'd2, 8'd1, 6'b100000, 1'b1);
        @(negedge clk);
        #1;
        reset  = 1'b0;
        switch = 1'b0;
        #2;
        reset  = 1'b1;
        edge_n = 0;
        goto(1); chk("async_rst",   S_AR, 2'd0, 8'd0, 6'b000000, 1'b0);
        goto(2); chk("rst_g0",      S_G,  2'd0, 8'd7, 6'b000001, 1'b0);
        step();
        @(negedge clk);
        #1;

        // Direct end-of-run checks: third edge after reset is GREEN phase 0 counter 6.
        n_checks++;
        if (state_o !== S_G) begin
            n_fail++;
            $display("FAIL final_state: got %0d expected %0d", state_o, S_G);
        end
        n_checks++;
        if (phase_o !== 2'd0) begin
            n_fail++;
            $display("FAIL final_phase: got %0d expected 0", phase_o);
        end
        n_checks++;
        if (counter_o !== 8'd6) begin
            n_fail++;
            $display("FAIL final_counter: got %0d expected 6", counter_o);
        end
        n_checks++;
        if (lights_o !== 6'b000001) begin
            n_fail++;
            $display("FAIL final_lights: got %b expected 000001", lights_o);
        end
        n_checks++;
        if (req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL final_req: got %b expected 0", req_o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
Name: traffic_phase_controller

Overview:
- Parametrised multi-phase traffic-light sequencer; successor to the 2-bit single-road sequence_generator.
- Cycles NUM_PHASES approach phases through GREEN → YELLOW → ALL-RED, with a countdown per state.
- Adds a debounced manual-advance switch, a hold/freeze input and a night flashing-yellow mode.
- Sits between the board switch/mode inputs and the lamp driver; exposes counter and state for display/debug.

Parameters:
- NUM_PHASES, 4, number of conflicting approaches (2..8).
- CNT_W, 32, countdown width; every duration below must be ≤ 2^CNT_W-1.
- GREEN_CYCLES, 100, green duration (≥1).
- YELLOW_CYCLES, 30, yellow duration (≥1).
- ALLRED_CYCLES, 10, all-red clearance duration (≥1).
- MIN_GREEN, 20, green cycles that must elapse before a switch request may cut green short (1..GREEN_CYCLES).
- FLASH_CYCLES, 50, half-period of the flash blink (≥1).
- DEBOUNCE_CYCLES, 8, consecutive stable synchronised samples required on switch (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; active when 0.
- switch  in  1  raw manual-advance pushbutton; asynchronous to clk.
- hold  in  1  freeze: counter and state frozen while 1.
- flash_mode  in  1  night mode request.
- lights  out  2*NUM_PHASES  per-phase lamp code, phase p at [2p+1:2p]: 00 RED, 01 GREEN, 10 YELLOW, 11 DARK.
- phase  out  clog2(NUM_PHASES)  index of the phase that currently owns green/yellow.
- state  out  2  00 ALLRED, 01 GREEN, 10 YELLOW, 11 FLASH.
- counter  out  CNT_W  remaining cycles in the current state, counting down to 0.
- req_pending  out  1  latched, debounced advance request.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ALLRED, phase=0, counter=ALLRED_CYCLES-1, all lights RED, req_pending=0.
  - Debouncer cleared.
  - Reset mid-operation returns here immediately from any state.
- Countdown: every non-hold edge with counter>0 decrements. The transition happens on the edge where counter==0, loading the next state's duration-1. Each state therefore lasts exactly its duration in cycles.
- ALLRED at counter 0:
  - flash_mode=1 → FLASH, counter=FLASH_CYCLES-1, all lights YELLOW.
  - otherwise → GREEN, counter=GREEN_CYCLES-1.
- GREEN:
  - lights[phase]=GREEN; all other phases RED.
  - At counter 0 → YELLOW, counter=YELLOW_CYCLES-1.
  - Early exit: if req_pending=1 and elapsed green ≥ MIN_GREEN (counter ≤ GREEN_CYCLES-1-MIN_GREEN), go to YELLOW on the next edge and clear req_pending on that same edge.
- YELLOW:
  - lights[phase]=YELLOW; others RED.
  - At counter 0 → ALLRED, counter=ALLRED_CYCLES-1, phase = (phase==NUM_PHASES-1) ? 0 : phase+1.
- FLASH:
  - All phases toggle YELLOW ↔ DARK each time counter hits 0, then reload FLASH_CYCLES-1.
  - flash_mode=0 sampled on any edge → ALLRED, phase=0, counter=ALLRED_CYCLES-1, all RED.
  - Requests are ignored and cleared while in FLASH.
- flash_mode asserted in GREEN or YELLOW takes no effect until the next ALLRED expiry; safe clearance is never skipped.
- hold=1:
  - counter, state, phase and lights hold their values; flash blink freezes too.
  - Debouncer and req_pending keep operating, so a request taken during hold is honoured after release.
  - Reset overrides hold.
- Switch path:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES identical synchronised samples.
  - A debounced rising edge sets req_pending. switch high sampled at edge k gives req_pending=1 after edge k+2+DEBOUNCE_CYCLES.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored. Holding the switch produces exactly one request.
  - A request arriving while req_pending=1 is merged into the pending one.
- Simultaneous events:
  - Natural expiry and early exit in GREEN both go to YELLOW; req_pending is cleared.
  - Debounced edge on the same edge req_pending is cleared: the new request wins and stays set.

Decomposition:
- Shared package traffic_pkg: state encoding constants (ST_ALLRED/GREEN/YELLOW/FLASH), lamp code constants (LAMP_RED/GREEN/YELLOW/DARK).
- One sub-module: switch_debouncer (synchroniser + stability counter + rising-edge pulse), parameter DEBOUNCE_CYCLES.

Test Plan:
All scenarios use NUM_PHASES=3, GREEN=8, YELLOW=3, ALLRED=2, MIN_GREEN=4, FLASH=5, DEBOUNCE=4.
1. Release reset, no inputs → ALLRED counter 1,0; GREEN phase0 counter 7..0; YELLOW 2..0; ALLRED; phase1 … after 39 cycles back to GREEN phase0; lights=000000 during ALLRED, phase0 green = 6'b000001.
2. switch high 10 cycles at GREEN counter=7 → req_pending after 6 edges; YELLOW entered when counter ≤3; req_pending cleared; only one request.
3. switch 3-cycle glitch → req_pending stays 0; full 8-cycle green.
4. hold high 5 cycles in YELLOW counter=1 → counter stays 1 and lights unchanged for 5 cycles, then resumes; phase advances normally.
5. flash_mode=1 during GREEN phase1 → completes YELLOW and ALLRED, enters FLASH, lights toggle 101010/111111 every 5 cycles; drop flash_mode → ALLRED phase0 counter 1.
6. reset pulsed low mid-YELLOW phase2 → immediately ALLRED, phase0, counter=1, req_pending=0.
